// File: rtl/mipsfpga_ahb_ps2.sv
// PS/2 keyboard receiver as an AHB-lite slave: deserialises frames, checks parity/stop bits,
// buffers bytes in a FIFO and exposes DATA/STATUS/CTRL registers plus a level interrupt.
module mipsfpga_ahb_ps2 #(
  parameter int FIFO_AW        = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  HADDR_d,
  input  logic        HVALID_d,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE_d,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        ps2_irq
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rxState_e;

  // Synchroniser and edge-detect state
  logic clkMeta_q, clkSync_q, clkPrev_q;
  logic dataMeta_q, dataSync_q;
  logic fall;

  // Receiver state
  rxState_e        state_q;
  logic [2:0]      bitCnt_q;
  logic [7:0]      shift_q;
  logic            parBit_q;
  logic [TW-1:0]   tmo_q;
  logic            push_q;
  logic [7:0]      pushByte_q;
  logic            frameSet_q;
  logic            parSet_q;

  // FIFO and register state
  logic [7:0]       mem_q [DEPTH];
  logic [CNT_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count;
  logic             notEmpty, fullFlag;
  logic             ovf_q, parErr_q, frameErr_q;
  logic             en_q, ie_q;

  logic acc, rdAcc, wrAcc, pop, doPush, w1c;
  logic unused_ok;

  assign unused_ok = &{1'b0, HWDATA[31:5]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      clkMeta_q  <= 1'b1;
      clkSync_q  <= 1'b1;
      clkPrev_q  <= 1'b1;
      dataMeta_q <= 1'b1;
      dataSync_q <= 1'b1;
    end else begin
      clkMeta_q  <= ps2_clk;
      clkSync_q  <= clkMeta_q;
      clkPrev_q  <= clkSync_q;
      dataMeta_q <= ps2_data;
      dataSync_q <= dataMeta_q;
    end
  end

  assign fall = clkPrev_q & ~clkSync_q;

  // Receiver FSM; the push and error flags are one-cycle registered pulses.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      bitCnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      parBit_q   <= 1'b0;
      tmo_q      <= '0;
      push_q     <= 1'b0;
      pushByte_q <= 8'd0;
      frameSet_q <= 1'b0;
      parSet_q   <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      frameSet_q <= 1'b0;
      parSet_q   <= 1'b0;
      if (!en_q) begin
        state_q <= IDLE;
        tmo_q   <= '0;
      end else if (fall) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dataSync_q) begin
              state_q  <= DATA;
              bitCnt_q <= 3'd0;
            end else begin
              frameSet_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q  <= {dataSync_q, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parBit_q <= dataSync_q;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (!dataSync_q) begin
              frameSet_q <= 1'b1;
            end else if (^{shift_q, parBit_q}) begin
              push_q     <= 1'b1;
              pushByte_q <= shift_q;
            end else begin
              parSet_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_q    <= IDLE;
          tmo_q      <= '0;
          frameSet_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign count    = wptr_q - rptr_q;
  assign notEmpty = (count != '0);
  assign fullFlag = (count == CNT_W'(DEPTH));

  assign acc    = HSEL & HVALID_d;
  assign rdAcc  = acc & ~HWRITE_d;
  assign wrAcc  = acc & HWRITE_d;
  assign pop    = rdAcc & (HADDR_d == ADDR_DATA) & notEmpty;
  assign doPush = push_q & (~fullFlag | pop);
  assign w1c    = wrAcc & (HADDR_d == ADDR_STATUS);

  // When full, a simultaneous pop frees the head slot, which is exactly where wptr points.
  always_ff @(posedge HCLK) begin
    if (doPush) mem_q[wptr_q[FIFO_AW-1:0]] <= pushByte_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      parErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
    end else begin
      if (doPush) wptr_q <= wptr_q + 1'b1;
      if (pop)    rptr_q <= rptr_q + 1'b1;
      ovf_q      <= (ovf_q & ~(w1c & HWDATA[2])) | (push_q & fullFlag & ~pop);
      parErr_q   <= (parErr_q & ~(w1c & HWDATA[3])) | parSet_q;
      frameErr_q <= (frameErr_q & ~(w1c & HWDATA[4])) | frameSet_q;
      if (wrAcc && (HADDR_d == ADDR_CTRL)) begin
        en_q <= HWDATA[0];
        ie_q <= HWDATA[1];
      end
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    case (HADDR_d)
      ADDR_DATA: begin
        if (notEmpty) HRDATA[8:0] = {1'b1, mem_q[rptr_q[FIFO_AW-1:0]]};
      end
      ADDR_STATUS: begin
        HRDATA[4:0]  = {frameErr_q, parErr_q, ovf_q, fullFlag, notEmpty};
        HRDATA[15:8] = 8'(count);
      end
      ADDR_CTRL: HRDATA[1:0] = {ie_q, en_q};
      default:   HRDATA = 32'd0;
    endcase
  end

  assign ps2_irq = ie_q & notEmpty;

endmodule

// File: tb/tb_mipsfpga_ahb_ps2.sv
// Self-checking bench for mipsfpga_ahb_ps2: a PS/2 host model drives frames while a queue-based
// reference model predicts DATA/STATUS/CTRL reads and the interrupt level.
module tb_mipsfpga_ahb_ps2;

  localparam int TMO   = 50000;
  localparam int DEPTH = 16;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  HADDR_d;
  logic        HVALID_d;
  logic [31:0] HWDATA;
  logic        HWRITE_d;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        ps2_clk;
  logic        ps2_data;
  logic        ps2_irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  bit modelEn, modelIe, modelOvf, modelPar, modelFrm;
  int lat;

  mipsfpga_ahb_ps2 #(.FIFO_AW(4), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR_d(HADDR_d), .HVALID_d(HVALID_d),
    .HWDATA(HWDATA), .HWRITE_d(HWRITE_d), .HSEL(HSEL), .HRDATA(HRDATA),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_irq(ps2_irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s = 32'd0;
    s[0] = (q.size() != 0);
    s[1] = (q.size() == DEPTH);
    s[2] = modelOvf;
    s[3] = modelPar;
    s[4] = modelFrm;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  function automatic void modelReset();
    q.delete();
    modelEn = 0; modelIe = 0; modelOvf = 0; modelPar = 0; modelFrm = 0;
  endfunction

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HVALID_d = 1'b1; HWRITE_d = 1'b0; HADDR_d = a;
    #1 d = HRDATA;
    @(negedge HCLK);
    HSEL = 1'b0; HVALID_d = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] v);
    @(negedge HCLK);
    HSEL = 1'b1; HVALID_d = 1'b1; HWRITE_d = 1'b1; HADDR_d = a; HWDATA = v;
    @(negedge HCLK);
    HSEL = 1'b0; HVALID_d = 1'b0; HWRITE_d = 1'b0;
    if (a == 2'd1) begin
      if (v[2]) modelOvf = 0;
      if (v[3]) modelPar = 0;
      if (v[4]) modelFrm = 0;
    end else if (a == 2'd2) begin
      modelEn = v[0]; modelIe = v[1];
    end
  endtask

  task automatic readData(input string tag);
    logic [31:0] d, e;
    busRead(2'd0, d);
    e = 32'd0;
    if (q.size() != 0) e = {23'd0, 1'b1, q.pop_front()};
    checkOutput(tag, d, e);
  endtask

  task automatic checkStatus(input string tag);
    logic [31:0] d;
    busRead(2'd1, d);
    checkOutput(tag, d, modelStatus());
  endtask

  task automatic checkIrq(input string tag);
    checkOutput(tag, {31'd0, ps2_irq}, {31'd0, modelIe && (q.size() != 0)});
  endtask

  task automatic ps2Bit(input logic b);
    repeat (4) @(negedge HCLK);
    ps2_data = b;
    repeat (4) @(negedge HCLK);
    ps2_clk = 1'b0;
    repeat (8) @(negedge HCLK);
    ps2_clk = 1'b1;
  endtask

  // mode 0: plain frame; 1: measure stop-edge to count-change latency; 2: DATA read in the push cycle
  task automatic applyStimulus(input logic [7:0] b, input bit badPar, input logic stopBit, input int mode);
    logic par;
    logic [31:0] d;
    logic [7:0] prevCount;
    par = ~(^b) ^ badPar;
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(b[i]);
    ps2Bit(par);
    repeat (4) @(negedge HCLK);
    ps2_data = stopBit;
    repeat (4) @(negedge HCLK);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      prevCount = 8'(q.size());
      lat = -1;
      for (int i = 0; i <= 8; i++) begin
        if (i > 0) @(negedge HCLK);
        HSEL = 1'b1; HVALID_d = 1'b1; HWRITE_d = 1'b0; HADDR_d = 2'd1;
        #1;
        if (lat < 0 && HRDATA[15:8] != prevCount) lat = i;
      end
      HSEL = 1'b0; HVALID_d = 1'b0;
    end else if (mode == 2) begin
      repeat (lat - 1) @(negedge HCLK);
      HSEL = 1'b1; HVALID_d = 1'b1; HWRITE_d = 1'b0; HADDR_d = 2'd0;
      #1 d = HRDATA;
      checkOutput("coincide_head", d, {23'd0, 1'b1, q.pop_front()});
      @(negedge HCLK);
      HSEL = 1'b0; HVALID_d = 1'b0;
    end
    repeat (8) @(negedge HCLK);
    ps2_clk = 1'b1;
    repeat (12) @(negedge HCLK);
    if (modelEn) begin
      if (!stopBit) modelFrm = 1;
      else if (badPar) modelPar = 1;
      else if (q.size() < DEPTH) q.push_back(b);
      else modelOvf = 1;
    end
  endtask

  task automatic drainAll(input string tag);
    while (q.size() != 0) readData(tag);
    readData({tag, "_empty"});
  endtask

  initial begin
    logic [31:0] d;
    HRESETn = 1'b0; HADDR_d = 2'd0; HVALID_d = 1'b0; HWDATA = 32'd0; HWRITE_d = 1'b0;
    HSEL = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    lat = 4;
    modelReset();
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;

    // Reset state
    checkStatus("reset_status");
    busRead(2'd2, d); checkOutput("reset_ctrl", d, 32'd0);
    readData("reset_data");
    checkIrq("reset_irq");
    busRead(2'd3, d); checkOutput("addr3_read", d, 32'd0);

    // Single good frame 0x1C, with latency measurement
    busWrite(2'd2, 32'd1);
    applyStimulus(8'h1C, 0, 1'b1, 1);
    checkOutput("latency_le4", {31'd0, (lat >= 1 && lat <= 4)}, 32'd1);
    checkStatus("one_byte_status");
    readData("one_byte_data");
    readData("one_byte_empty");
    busWrite(2'd3, 32'hFFFF_FFFF);
    busRead(2'd3, d); checkOutput("addr3_write_ignored", d, 32'd0);

    // 17 frames into a 16-deep FIFO
    for (int i = 0; i <= 16; i++) applyStimulus(8'(i), 0, 1'b1, 0);
    checkStatus("overflow_status");
    checkIrq("irq_ie0");
    drainAll("overflow_drain");
    busWrite(2'd1, 32'h04);
    checkStatus("ovf_w1c");

    // Parity error, then W1C
    applyStimulus(8'h1C, 1, 1'b1, 0);
    readData("parerr_data");
    checkStatus("parerr_status");
    busWrite(2'd1, 32'h08);
    checkStatus("parerr_clear");

    // Stop bit error and a start bit of 1
    applyStimulus(8'hA5, 0, 1'b0, 0);
    checkStatus("stoperr_status");
    busWrite(2'd1, 32'h10);
    ps2Bit(1'b1);
    repeat (12) @(negedge HCLK);
    modelFrm = 1;
    checkStatus("starterr_status");
    busWrite(2'd1, 32'h10);

    // Disabling mid-frame aborts the partial frame
    ps2Bit(1'b0); ps2Bit(1'b1); ps2Bit(1'b0);
    busWrite(2'd2, 32'd0);
    busWrite(2'd2, 32'd1);
    applyStimulus(8'h3C, 0, 1'b1, 0);
    readData("en_abort_data");

    // Timeout after 5 data bits
    ps2Bit(1'b0);
    for (int i = 0; i < 5; i++) ps2Bit(1'b1);
    repeat (TMO - 100) @(negedge HCLK);
    checkStatus("timeout_before");
    repeat (200) @(negedge HCLK);
    modelFrm = 1;
    checkStatus("timeout_after");
    applyStimulus(8'h5A, 0, 1'b1, 0);
    readData("after_timeout_data");
    busWrite(2'd1, 32'h1C);

    // Full FIFO: push coincides with a DATA pop
    for (int i = 0; i < DEPTH; i++) applyStimulus(8'($urandom), 0, 1'b1, 0);
    applyStimulus(8'hE7, 0, 1'b1, 2);
    checkStatus("coincide_status");
    drainAll("coincide_drain");

    // Randomised traffic
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 6))
        0, 1: applyStimulus(8'($urandom), 0, 1'b1, 0);
        2:    applyStimulus(8'($urandom), 1, 1'b1, 0);
        3:    applyStimulus(8'($urandom), 0, 1'b0, 0);
        4:    readData("rand_data");
        5:    checkStatus("rand_status");
        default: begin
          busWrite(2'd1, {27'd0, 5'($urandom)});
          checkStatus("rand_w1c");
        end
      endcase
    end
    drainAll("rand_drain");
    busWrite(2'd1, 32'h1C);

    // Interrupt and mid-frame reset
    busWrite(2'd2, 32'd3);
    applyStimulus(8'h77, 0, 1'b1, 0);
    checkIrq("irq_set");
    readData("irq_pop");
    #1 checkIrq("irq_clear");
    applyStimulus(8'h12, 0, 1'b1, 0);
    checkIrq("irq_set2");
    ps2Bit(1'b0); ps2Bit(1'b1); ps2Bit(1'b1);
    @(negedge HCLK);
    HRESETn = 1'b0;
    modelReset();
    HADDR_d = 2'd0; #1 checkOutput("rst_data", HRDATA, 32'd0);
    HADDR_d = 2'd1; #1 checkOutput("rst_status", HRDATA, 32'd0);
    HADDR_d = 2'd2; #1 checkOutput("rst_ctrl", HRDATA, 32'd0);
    checkOutput("rst_irq", {31'd0, ps2_irq}, 32'd0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    busWrite(2'd2, 32'd1);
    applyStimulus(8'hC3, 0, 1'b1, 0);
    checkStatus("post_reset_status");
    readData("post_reset_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
